// File: rtl/dino_pkg.sv
// dino_pkg: shared obstacle types, spawner defaults and FSM encoding for the Dino game.
package dino_pkg;
    localparam logic [1:0] OBS_CACTUS_S = 2'b00;
    localparam logic [1:0] OBS_CACTUS_L = 2'b01;
    localparam logic [1:0] OBS_BIRD_LO  = 2'b10;
    localparam logic [1:0] OBS_BIRD_HI  = 2'b11;
    localparam int SPAWN_X_DEF = 159;
    localparam int MIN_GAP_DEF = 40;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_SPAWN = 2'd2;
endpackage

// File: rtl/obstacle_spawner_if.sv
// obstacle_spawner_if: game control inputs, LFSR link and the two obstacle slot outputs.
interface obstacle_spawner_if #(
    parameter int RNG_BITS = 8,
    parameter int X_BITS   = 8
);
    logic                game_tick;
    logic                game_active;
    logic [2:0]          speed;
    logic [RNG_BITS-1:0] rand_data;
    logic                lfsr_enable;
    logic                obs0_valid;
    logic                obs1_valid;
    logic [X_BITS-1:0]   obs0_x;
    logic [X_BITS-1:0]   obs1_x;
    logic [1:0]          obs0_type;
    logic [1:0]          obs1_type;
    logic                spawn_pulse;

    modport master (
        input  game_tick, game_active, speed, rand_data,
        output lfsr_enable, obs0_valid, obs1_valid, obs0_x, obs1_x, obs0_type, obs1_type, spawn_pulse
    );
    modport slave (
        output game_tick, game_active, speed, rand_data,
        input  lfsr_enable, obs0_valid, obs1_valid, obs0_x, obs1_x, obs0_type, obs1_type, spawn_pulse
    );
endinterface

// File: rtl/obstacle_slot.sv
// obstacle_slot: one scrolling obstacle; load wins over move so a fresh spawn stays at the edge.
module obstacle_slot
    import dino_pkg::*;
#(
    parameter int X_BITS  = 8,
    parameter int SPAWN_X = SPAWN_X_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              load,
    input  logic [1:0]        load_type,
    input  logic [X_BITS-1:0] step,
    input  logic              clear,
    output logic              valid,
    output logic [X_BITS-1:0] x,
    output logic [1:0]        obs_type
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            x        <= '0;
            obs_type <= OBS_CACTUS_S;
        end else if (clear || (tick && !load && valid && x < step)) begin
            valid    <= 1'b0;
            x        <= '0;
            obs_type <= OBS_CACTUS_S;
        end else if (tick && load) begin
            valid    <= 1'b1;
            x        <= X_BITS'(SPAWN_X);
            obs_type <= load_type;
        end else if (tick && valid) begin
            x        <= x - step;
        end
    end
endmodule

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: gap-timed spawn FSM feeding two scrolling obstacle slots from LFSR data.
module obstacle_spawner
    import dino_pkg::*;
#(
    parameter int X_BITS  = 8,
    parameter int SPAWN_X = SPAWN_X_DEF,
    parameter int MIN_GAP = MIN_GAP_DEF
) (
    input logic clk,
    input logic rst,
    obstacle_spawner_if.master bus
);
    logic [1:0]        state;
    logic [6:0]        gap_cnt;
    logic [6:0]        gap_load;
    logic              spawn_pulse;
    logic              tick;
    logic              do_spawn;
    logic              v0;
    logic              v1;
    logic [X_BITS-1:0] step;

    assign gap_load         = 7'(MIN_GAP) + {1'b0, bus.rand_data[5:0]};
    assign step             = X_BITS'(bus.speed) + X_BITS'(1);
    assign tick             = bus.game_active && bus.game_tick;
    // free-slot test uses pre-tick valids, so a slot emptied this tick waits one more
    assign do_spawn         = tick && state == ST_SPAWN && !(v0 && v1);
    assign bus.lfsr_enable  = bus.game_active;
    assign bus.spawn_pulse  = spawn_pulse;
    assign bus.obs0_valid   = v0;
    assign bus.obs1_valid   = v1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            spawn_pulse <= 1'b0;
        end else if (!bus.game_active) begin
            state       <= ST_IDLE;
            gap_cnt     <= '0;
            spawn_pulse <= 1'b0;
        end else begin
            spawn_pulse <= do_spawn;
            if (state == ST_IDLE) begin
                state   <= ST_WAIT;
                gap_cnt <= gap_load;
            end else if (tick && state == ST_WAIT) begin
                if (gap_cnt == 7'd1) state <= ST_SPAWN;
                else gap_cnt <= gap_cnt - 7'd1;
            end else if (do_spawn) begin
                state   <= ST_WAIT;
                gap_cnt <= gap_load;
            end
        end
    end

    obstacle_slot #(.X_BITS(X_BITS), .SPAWN_X(SPAWN_X)) u_slot0 (
        .clk(clk), .rst(rst), .tick(tick), .load(do_spawn && !v0),
        .load_type(bus.rand_data[7:6]), .step(step), .clear(!bus.game_active),
        .valid(v0), .x(bus.obs0_x), .obs_type(bus.obs0_type)
    );

    obstacle_slot #(.X_BITS(X_BITS), .SPAWN_X(SPAWN_X)) u_slot1 (
        .clk(clk), .rst(rst), .tick(tick), .load(do_spawn && v0),
        .load_type(bus.rand_data[7:6]), .step(step), .clear(!bus.game_active),
        .valid(v1), .x(bus.obs1_x), .obs_type(bus.obs1_type)
    );
endmodule

// File: doc/obstacle_spawner.md
Name: obstacle_spawner

Overview:
- Downstream consumer of the 8-bit LFSR in the Dino game.
- Samples `rand_data` on frame ticks to pick random inter-obstacle gaps and obstacle types.
- Maintains two scrolling obstacle slots and drives their x-position and type to the renderer/collision logic.
- Drives the LFSR `enable`, which must stay high while the game runs or the LFSR reseeds to 0x55.

Parameters:
- RNG_BITS, 8, width of `rand_data` (bits [5:0] = gap, bits [7:6] = type); must be 8
- X_BITS, 8, width of obstacle x coordinate
- SPAWN_X, 159, x loaded into a slot on spawn (right screen edge)
- MIN_GAP, 40, minimum gap in game ticks between spawns; must be ≥1

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- game_tick  in  1  one-clk pulse per frame; all state advances only on this pulse
- game_active  in  1  level; high while game is running
- speed  in  3  scroll step minus one (step = speed+1 pixels/tick)
- rand_data  in  RNG_BITS  LFSR output
- lfsr_enable  out  1  to LFSR enable; combinational equal to game_active
- obs0_valid / obs1_valid  out  1  slot occupied
- obs0_x / obs1_x  out  X_BITS  slot x position
- obs0_type / obs1_type  out  2  00 small cactus, 01 large cactus, 10 bird low, 11 bird high
- spawn_pulse  out  1  one-clk pulse in the cycle after a spawn is committed

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, gap_cnt=0.
  - All valid/x/type outputs are 0 and spawn_pulse is 0.
- FSM states IDLE, WAIT, SPAWN. All outputs are registered except lfsr_enable.
- game_active=0 (any state, synchronous) takes priority over game_tick:
  - Next clk: state=IDLE, both slots valid=0, x=0, type=0, gap_cnt=0.
- IDLE→WAIT on the first clk with game_active=1, whether or not a tick is present:
  - gap_cnt ← MIN_GAP + rand_data[5:0], as a 7-bit zero-extended add (range 40..103).
- WAIT, on game_tick:
  - If gap_cnt==1, state→SPAWN.
  - Otherwise gap_cnt ← gap_cnt-1.
  - Non-tick cycles hold all state.
- SPAWN, on game_tick:
  - The free-slot check uses registered valid values from before this tick, lowest index first.
  - If a slot is free: set valid=1, x=SPAWN_X, type=rand_data[7:6]; pulse spawn_pulse the next cycle; gap_cnt ← MIN_GAP + rand_data[5:0]; state→WAIT.
  - If no slot is free: stay in SPAWN, no pulse, gap not reloaded; retry on every subsequent tick.
  - A gap of G therefore produces a spawn on the (G+1)th tick after loading.
- Scroll, on game_tick, for each slot valid before the tick:
  - If x < speed+1, the slot goes valid=0, x=0, type=0.
  - Otherwise x ← x-(speed+1).
  - A slot freed on tick t is not reusable until tick t+1.
  - A slot spawned on tick t is not moved on tick t.
- `speed` is sampled on each tick; a change applies to all valid slots from that tick.
- Non-tick cycles: no output change, and spawn_pulse returns to 0.

Decomposition:
- Package dino_pkg holds:
  - obstacle type constants OBS_CACTUS_S/OBS_CACTUS_L/OBS_BIRD_LO/OBS_BIRD_HI;
  - SPAWN_X and MIN_GAP defaults;
  - the FSM state encoding.
- Sub-module obstacle_slot, instantiated twice:
  - holds valid/x/type;
  - inputs load, load_type, tick, step, clear;
  - performs the move and underflow-clear logic.
- The spawner FSM and gap counter live in obstacle_spawner.

Test Plan:
- Reset mid-run: assert rst with both slots valid → all outputs 0 immediately (async); after release, remains IDLE until game_active is seen.
- Start with the bench driving rand_data=0x55 constantly:
  - gap=61 loaded.
  - obs0 valid on the 62nd tick with x=159, type=01; spawn_pulse high for exactly one cycle.
  - Next spawn occurs 62 ticks later, into obs1.
- Scroll boundary with speed=3: obs0 goes 159,155,…,3 over 39 ticks, then valid=0 on the next tick; the slot is reused by the next spawn.
- Slots full at gap expiry:
  - spawn_pulse stays low while the FSM holds in SPAWN.
  - obs0 frees on tick t; the spawn into obs0 occurs on tick t+1, not t.
- game_active drops while in WAIT with both slots valid → next clk all valid=0, lfsr_enable=0, IDLE; game_tick asserted in that cycle is ignored.
- Hold: non-tick cycles with random rand_data/speed changes → no output change.
